// File: rtl/counter_sequencer_pkg.sv
// Shared encodings and sizing helpers for the counter sequencer.
package counter_sequencer_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned COUNT_W = 8;

    // Sequencer states; 2'd3 is unused and recovers to ST_CLEAR.
    typedef enum logic [STATE_W-1:0] {
        ST_CLEAR = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold max_val without wrapping (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? int'($clog2(max_val + 1)) : 1;
    endfunction

endpackage

// File: rtl/counter_sequencer_button_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse
// for one raw pushbutton.
module button_debounce
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // State registers; everything clears to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive cycles the synchronized input differs from the
    // accepted level; accept on the last one and pulse only on a press.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/clear/direction sequencer driving an external up/down counter
// from three debounced pushbuttons.
// Optional feature macro: AUTO_REVERSE_EN (reverse direction at 8'hFF/8'h00
// while running).
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CLR_CYCLES      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_run,
    input  logic               btn_dir,
    input  logic               btn_clr,
    input  logic [COUNT_W-1:0] count,
    output logic               cnt_incdec,
    output logic               cnt_stop,
    output logic               cnt_rst,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned      TMR_W    = cnt_width(CLR_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLR_CYCLES - 1);

    logic run_p, dir_p, clr_p;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q,   tmr_d;
    logic             dir_q,   dir_d;
    logic             stop_q,  stop_d;
    logic             rst_q,   rst_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_run),
        .press_o (run_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_dir),
        .press_o (dir_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_clr),
        .press_o (clr_p)
    );

    // State, timer, direction and registered counter controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            tmr_q   <= TMR_LOAD;
            dir_q   <= DIR_UP;
            stop_q  <= 1'b1;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            dir_q   <= dir_d;
            stop_q  <= stop_d;
            rst_q   <= rst_d;
        end
    end

    // Next state: clear beats run; outputs are decoded from the next state
    // so they change on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_p) begin
                    tmr_d = TMR_LOAD;
                end else if (tmr_q == '0) begin
                    state_d = ST_PAUSE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_PAUSE: begin
                if (clr_p) begin
                    state_d = ST_CLEAR;
                    tmr_d   = TMR_LOAD;
                end else if (run_p) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clr_p) begin
                    state_d = ST_CLEAR;
                    tmr_d   = TMR_LOAD;
                end else if (run_p) begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                tmr_d   = TMR_LOAD;
            end
        endcase
        stop_d = (state_d != ST_RUN);
        rst_d  = (state_d == ST_CLEAR);
    end

    // Direction toggles on a dir press in any state; a press outranks
    // the boundary reversal.
    always_comb begin
        dir_d = dir_q;
        if (dir_p) begin
            dir_d = ~dir_q;
        end
`ifdef AUTO_REVERSE_EN
        else if ((state_q == ST_RUN) && (dir_q == DIR_UP) && (count == '1)) begin
            dir_d = DIR_DOWN;
        end else if ((state_q == ST_RUN) && (dir_q == DIR_DOWN) && (count == '0)) begin
            dir_d = DIR_UP;
        end
`endif
    end

`ifndef AUTO_REVERSE_EN
    // Counter value only matters for auto-reverse.
    logic unused_count;
    assign unused_count = ^count;
`endif

    assign cnt_incdec = dir_q;
    assign cnt_stop   = stop_q;
    assign cnt_rst    = rst_q;
    assign state      = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with DEBOUNCE_CYCLES=4, CLR_CYCLES=2.
module tb_counter_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn_run;
    logic       btn_dir;
    logic       btn_clr;
    logic [7:0] count;
    logic       cnt_incdec;
    logic       cnt_stop;
    logic       cnt_rst;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_PAUSE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    counter_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .CLR_CYCLES      (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_run    (btn_run),
        .btn_dir    (btn_dir),
        .btn_clr    (btn_clr),
        .count      (count),
        .cnt_incdec (cnt_incdec),
        .cnt_stop   (cnt_stop),
        .cnt_rst    (cnt_rst),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: hold one button for 'hold' cycles, then idle.
    task automatic press_clean(input int which, input int hold, input int settle);
        if (which == 0) btn_run = 1'b1;
        else if (which == 1) btn_dir = 1'b1;
        else btn_clr = 1'b1;
        repeat (hold) @(negedge clk);
        btn_run = 1'b0;
        btn_dir = 1'b0;
        btn_clr = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== S_CLEAR) begin failures++; $display("FAIL rst_state: got %0d expected %0d", state, S_CLEAR); end
        checks++; if (cnt_rst !== 1'b1) begin failures++; $display("FAIL rst_cnt_rst: got %0b expected 1", cnt_rst); end
        checks++; if (cnt_stop !== 1'b1) begin failures++; $display("FAIL rst_cnt_stop: got %0b expected 1", cnt_stop); end
        checks++; if (cnt_incdec !== 1'b1) begin failures++; $display("FAIL rst_incdec: got %0b expected 1", cnt_incdec); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (cnt_rst === 1'b1) n++;
            @(negedge clk);
        end
        checks++; if (n != 2) begin failures++; $display("FAIL rel_rst_cycles: got %0d expected 2", n); end
        checks++; if (state !== S_PAUSE) begin failures++; $display("FAIL rel_state: got %0d expected %0d", state, S_PAUSE); end
        checks++; if (cnt_stop !== 1'b1) begin failures++; $display("FAIL rel_cnt_stop: got %0b expected 1", cnt_stop); end
        checks++; if (cnt_incdec !== 1'b1) begin failures++; $display("FAIL rel_incdec: got %0b expected 1", cnt_incdec); end
    endtask

    task automatic test_dir;
        logic exp_b;
        for (int k = 0; k < 2; k++) begin
            exp_b = (k == 0) ? 1'b1 : 1'b0;
            btn_dir = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (i == 6) begin
                    checks++;
                    if (cnt_incdec !== exp_b) begin failures++; $display("FAIL dir_before_%0d: got %0b expected %0b", k, cnt_incdec, exp_b); end
                end
                if (i == 7) begin
                    checks++;
                    if (cnt_incdec !== ~exp_b) begin failures++; $display("FAIL dir_after_%0d: got %0b expected %0b", k, cnt_incdec, ~exp_b); end
                end
                if (i == 8) btn_dir = 1'b0;
            end
        end
        checks++; if (state !== S_PAUSE) begin failures++; $display("FAIL dir_state: got %0d expected %0d", state, S_PAUSE); end
    endtask

    task automatic test_run_bounce;
        logic [1:0] prev;
        int trans;
        int first_idx;
        trans = 0;
        first_idx = -1;
        prev = state;
        btn_run = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (state !== prev) begin
                trans++;
                if (first_idx < 0) first_idx = i;
            end
            prev = state;
            if (i == 1) btn_run = 1'b0;
            if (i == 2) btn_run = 1'b1;
            if (i == 12) btn_run = 1'b0;
        end
        checks++; if (trans != 1) begin failures++; $display("FAIL bounce_transitions: got %0d expected 1", trans); end
        checks++; if (first_idx != 9) begin failures++; $display("FAIL bounce_latency: got %0d expected 9", first_idx); end
        checks++; if (state !== S_RUN) begin failures++; $display("FAIL bounce_state: got %0d expected %0d", state, S_RUN); end
        checks++; if (cnt_stop !== 1'b0) begin failures++; $display("FAIL bounce_cnt_stop: got %0b expected 0", cnt_stop); end
        checks++; if (cnt_rst !== 1'b0) begin failures++; $display("FAIL bounce_cnt_rst: got %0b expected 0", cnt_rst); end
    endtask

    task automatic test_clr_run_same;
        int clear_idx;
        int pause_idx;
        int rst_n_cyc;
        int early_bad;
        clear_idx = -1;
        pause_idx = -1;
        rst_n_cyc = 0;
        early_bad = 0;
        btn_clr = 1'b1;
        btn_run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i <= 6 && state !== S_RUN) early_bad++;
            if (cnt_rst === 1'b1) rst_n_cyc++;
            if (state === S_CLEAR && clear_idx < 0) clear_idx = i;
            if (state === S_PAUSE && clear_idx >= 0 && pause_idx < 0) pause_idx = i;
            if (i == 6) begin
                btn_clr = 1'b0;
                btn_run = 1'b0;
            end
        end
        checks++; if (early_bad != 0) begin failures++; $display("FAIL same_early_change: got %0d expected 0", early_bad); end
        checks++; if (clear_idx != 7) begin failures++; $display("FAIL same_clear_idx: got %0d expected 7", clear_idx); end
        checks++; if (rst_n_cyc != 2) begin failures++; $display("FAIL same_rst_cycles: got %0d expected 2", rst_n_cyc); end
        checks++; if (pause_idx != 9) begin failures++; $display("FAIL same_pause_idx: got %0d expected 9", pause_idx); end
        checks++; if (state !== S_PAUSE) begin failures++; $display("FAIL same_final_state: got %0d expected %0d", state, S_PAUSE); end
        checks++; if (cnt_stop !== 1'b1) begin failures++; $display("FAIL same_cnt_stop: got %0b expected 1", cnt_stop); end
    endtask

    task automatic test_auto_reverse;
        int falls;
        int fall_idx;
        logic prev;
        press_clean(0, 8, 20);
        checks++; if (state !== S_RUN) begin failures++; $display("FAIL ar_enter_run: got %0d expected %0d", state, S_RUN); end
        falls = 0;
        fall_idx = -1;
        prev = cnt_incdec;
        count = 8'hFF;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && cnt_incdec === 1'b0) begin
                falls++;
                if (fall_idx < 0) fall_idx = i;
            end
            prev = cnt_incdec;
        end
        count = 8'h00;
        @(negedge clk);
`ifdef AUTO_REVERSE_EN
        checks++; if (falls != 1) begin failures++; $display("FAIL ar_falls: got %0d expected 1", falls); end
        checks++; if (fall_idx != 1) begin failures++; $display("FAIL ar_fall_idx: got %0d expected 1", fall_idx); end
        checks++; if (prev !== 1'b0) begin failures++; $display("FAIL ar_held_down: got %0b expected 0", prev); end
        checks++; if (cnt_incdec !== 1'b1) begin failures++; $display("FAIL ar_restore_up: got %0b expected 1", cnt_incdec); end
`else
        checks++; if (falls != 0) begin failures++; $display("FAIL noar_falls: got %0d expected 0", falls); end
        checks++; if (prev !== 1'b1) begin failures++; $display("FAIL noar_held_up: got %0b expected 1", prev); end
        checks++; if (cnt_incdec !== 1'b1) begin failures++; $display("FAIL noar_zero_up: got %0b expected 1", cnt_incdec); end
`endif
        count = 8'h55;
        repeat (3) @(negedge clk);
        checks++; if (cnt_stop !== 1'b0) begin failures++; $display("FAIL ar_still_run: got %0b expected 0", cnt_stop); end
    endtask

    task automatic test_reset_mid_run;
        int n;
        int bad;
        press_clean(1, 8, 20);
        checks++; if (cnt_incdec !== 1'b0) begin failures++; $display("FAIL mid_pre_dir: got %0b expected 0", cnt_incdec); end
        checks++; if (state !== S_RUN) begin failures++; $display("FAIL mid_pre_state: got %0d expected %0d", state, S_RUN); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== S_CLEAR) begin failures++; $display("FAIL mid_state: got %0d expected %0d", state, S_CLEAR); end
        checks++; if (cnt_rst !== 1'b1) begin failures++; $display("FAIL mid_cnt_rst: got %0b expected 1", cnt_rst); end
        checks++; if (cnt_stop !== 1'b1) begin failures++; $display("FAIL mid_cnt_stop: got %0b expected 1", cnt_stop); end
        checks++; if (cnt_incdec !== 1'b1) begin failures++; $display("FAIL mid_incdec: got %0b expected 1", cnt_incdec); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (cnt_rst === 1'b1) n++;
            @(negedge clk);
        end
        checks++; if (n != 2) begin failures++; $display("FAIL mid_rel_rst_cycles: got %0d expected 2", n); end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (state !== S_PAUSE || cnt_incdec !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mid_spurious: got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        rst_n   = 1'b1;
        btn_run = 1'b0;
        btn_dir = 1'b0;
        btn_clr = 1'b0;
        count   = 8'h55;
        test_reset();
        test_dir();
        test_run_bounce();
        test_clr_run_same();
        test_auto_reverse();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
